counter_100: RTL and testbench
==============================

Name: counter_100

Overview:
- Free-running modulo-100 up-counter (0..99) with two independent, functionally identical register implementations exposed side by side.
- o_cnt uses a split style: a state register plus a separate combinational next-state block.
- o_cnt_always uses a single clocked always block that computes and registers the next count.
- Used as a basic timing/sequence source and as a coding-style cross-check: the two outputs must match on every cycle.

Parameters:
- CNT_WIDTH, 7, width of both count outputs; must satisfy 2**CNT_WIDTH > MAX_CNT.
- MAX_CNT, 99, terminal count; the value after MAX_CNT is 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- o_cnt  output  CNT_WIDTH  count from the split register + combinational next-state implementation.
- o_cnt_always  output  CNT_WIDTH  count from the single-always-block implementation.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n. No asynchronous reset path; reset_n is not in any sensitivity list.
- Reset: at any rising edge of clk with reset_n==0, both o_cnt and o_cnt_always become 0 in that cycle. They hold 0 for as long as reset_n stays low.
- Before the first reset: register contents are undefined. No initial values are required. Checking starts after the first reset edge.
- Counting: at each rising edge with reset_n==1:
  - if count == MAX_CNT, next = 0;
  - otherwise next = count + 1.
- Step size: exactly one increment per clock. There is no enable and no hold.
- Latency: the first rising edge after reset_n returns high produces a count of 1. Counts 0..99 each last one cycle, so the period is MAX_CNT+1 = 100 cycles.
- Wrap: the 99 -> 0 transition takes a single cycle. Values 100..127 are never produced.
- Defensive recovery: if a count > MAX_CNT is ever present (X-recovery, SEU), the next value is 0.
- Arithmetic: unsigned, CNT_WIDTH bits. The increment is computed at CNT_WIDTH or wider and truncated; no carry output.
- o_cnt implementation:
  - registered state cnt plus a combinational block producing cnt_next (reset dominant, then wrap compare, then increment);
  - the clocked block only does cnt <= cnt_next;
  - o_cnt = cnt, driven directly from the flop with no combinational logic on the output.
- o_cnt_always implementation:
  - one clocked always block containing the reset, wrap compare and increment;
  - output driven directly from the flop.
- Equivalence: o_cnt == o_cnt_always on every cycle after the first reset, including during reset and at wrap.
- Reset mid-count: reset asserted at any count, including 99 or 0, forces 0 on that edge. Counting resumes 1, 2, … from the following non-reset edge.
- Reset glitch: a reset_n low pulse that does not span a rising edge has no effect.
- Outputs: registered only; no combinational path from reset_n to either output.

Test Plan:
- Reset: run clk (10 ns period) with reset_n=1 for 100 ns, then drive reset_n=0 for one edge, then 1.
  -> both outputs 0 after the reset edge; 1 after the next edge; 2 after the one after.
- Full sequence: after reset release, sample for 100 edges.
  -> values 1, 2, …, 99, 0, each exactly once; o_cnt == o_cnt_always on every sample.
- Wrap boundary: at count 99, one clock.
  -> 0; next clock -> 1; never 100.
- Long run: 200 clocks after release.
  -> two complete wraps (0 seen at edges 100 and 200); outputs always equal and always ≤ 99.
- Reset mid-count: assert reset_n=0 at count 57 and hold 3 edges.
  -> 0 on each of the 3 edges; after release 1, 2, 3.
- Reset at terminal count, plus glitch:
  - assert reset at count 99 -> 0 (same as natural wrap), then 1 after release;
  - a reset_n low pulse between edges -> count continues uninterrupted.

Source files
------------

// File: rtl/counter_100.sv
// counter_100: free-running modulo-(MAX_CNT+1) up-counter.
// Two functionally identical implementations are exposed side by side:
//   o_cnt        - state register plus a separate combinational next-state block
//   o_cnt_always - a single clocked block that computes and registers the count
// Both outputs come straight from flops and must agree on every cycle after
// the first reset edge. Reset is synchronous and active-low.
module counter_100 #(
    parameter int CNT_WIDTH = 7,
    parameter int MAX_CNT   = 99
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic [CNT_WIDTH-1:0] o_cnt,
    output logic [CNT_WIDTH-1:0] o_cnt_always
);

    // Terminal count and unit step at the counter width, so every compare and
    // add below is width-matched and the increment truncates naturally.
    localparam logic [CNT_WIDTH-1:0] LP_MAX = CNT_WIDTH'(MAX_CNT);
    localparam logic [CNT_WIDTH-1:0] LP_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic [CNT_WIDTH-1:0] r_cnt_always;

    // Next-state for the split implementation: reset first, then wrap, then step.
    // The >= compare also pulls any out-of-range value (X-recovery, upset) back to 0.
    always_comb begin
        w_cnt_next = '0;
        if (!reset_n) begin
            w_cnt_next = '0;
        end else if (r_cnt >= LP_MAX) begin
            w_cnt_next = '0;
        end else begin
            w_cnt_next = r_cnt + LP_ONE;
        end
    end

    // State register for the split implementation: it only captures the next state.
    always_ff @(posedge clk) begin
        r_cnt <= w_cnt_next;
    end

    // Single-block implementation: reset, wrap and increment all in one clocked process.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt_always <= '0;
        end else if (r_cnt_always >= LP_MAX) begin
            r_cnt_always <= '0;
        end else begin
            r_cnt_always <= r_cnt_always + LP_ONE;
        end
    end

    assign o_cnt        = r_cnt;
    assign o_cnt_always = r_cnt_always;

endmodule

// File: tb/tb_counter_100.sv
// Testbench for counter_100: the expected count is derived from the number of
// non-reset rising edges since the most recent reset edge, taken modulo 100.
module tb_counter_100;

    localparam int CNT_WIDTH = 7;
    localparam int MAX_CNT   = 99;
    localparam int PERIOD    = MAX_CNT + 1;

    logic                 clk;
    logic                 reset_n;
    logic [CNT_WIDTH-1:0] o_cnt;
    logic [CNT_WIDTH-1:0] o_cnt_always;

    int n_tests;
    int n_fail;

    // Reference model state
    bit m_valid;
    int m_since;   // non-reset edges since the last reset edge

    counter_100 #(
        .CNT_WIDTH (CNT_WIDTH),
        .MAX_CNT   (MAX_CNT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .o_cnt        (o_cnt),
        .o_cnt_always (o_cnt_always)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Model: count = (edges since reset) mod period
    always @(posedge clk) begin
        if (reset_n === 1'b0) begin
            m_valid <= 1'b1;
            m_since <= 0;
        end else if (m_valid) begin
            m_since <= m_since + 1;
        end
    end

    // Per-cycle compare on the falling edge
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_cnt",        {25'd0, o_cnt},        32'(m_since % PERIOD));
            chk("model_cnt_always", {25'd0, o_cnt_always}, 32'(m_since % PERIOD));
            chk("outputs_equal",    {25'd0, o_cnt},        {25'd0, o_cnt_always});
            chk("in_range",         32'(o_cnt <= 7'(MAX_CNT)), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_for(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            if (int'(o_cnt) == target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_for_%0d: got %0d, expected %0d within budget", target, o_cnt, target);
        end
    endtask

    task automatic do_reset(input int edges);
        reset_n = 1'b0;
        for (int i = 0; i < edges; i++) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        bit ok;
        int seen [PERIOD];
        int once_cnt;
        int zero_cnt;
        int zero_pos [2];
        int v;
        int bad_range;

        n_tests = 0;
        n_fail  = 0;
        m_valid = 1'b0;
        m_since = 0;
        reset_n = 1'b1;

        // Free-run before any reset; outputs are undefined and not checked
        #100;
        @(posedge clk);
        #2;

        // Reset for one edge, then 1, 2
        reset_n = 1'b0;
        tick();
        chk("reset_cnt",        {25'd0, o_cnt},        32'd0);
        chk("reset_cnt_always", {25'd0, o_cnt_always}, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("after_rst_1", {25'd0, o_cnt}, 32'd1);
        tick();
        chk("after_rst_2", {25'd0, o_cnt}, 32'd2);

        // Wrap boundary: 99 -> 0 -> 1
        for (int i = 0; i < 97; i++) tick();
        chk("reach_99", {25'd0, o_cnt}, 32'd99);
        tick();
        chk("wrap_0",        {25'd0, o_cnt},        32'd0);
        chk("wrap_0_always", {25'd0, o_cnt_always}, 32'd0);
        tick();
        chk("wrap_1", {25'd0, o_cnt}, 32'd1);

        // Full sequence: 100 edges after release, each value exactly once
        do_reset(1);
        for (int i = 0; i < PERIOD; i++) seen[i] = 0;
        bad_range = 0;
        for (int e = 1; e <= PERIOD; e++) begin
            tick();
            if (int'(o_cnt) < PERIOD) seen[int'(o_cnt)]++;
            else bad_range++;
            if (e == PERIOD) chk("full_seq_last", {25'd0, o_cnt}, 32'd0);
        end
        once_cnt = 0;
        for (int i = 0; i < PERIOD; i++) if (seen[i] == 1) once_cnt++;
        chk("full_seq_each_once", 32'(once_cnt), 32'(PERIOD));
        chk("full_seq_range", 32'(bad_range), 32'd0);

        // Long run: 200 edges, zeros at edges 100 and 200 only
        do_reset(1);
        zero_cnt = 0;
        zero_pos[0] = -1;
        zero_pos[1] = -1;
        for (int e = 1; e <= 2 * PERIOD; e++) begin
            tick();
            if (o_cnt == '0) begin
                if (zero_cnt < 2) zero_pos[zero_cnt] = e;
                zero_cnt++;
            end
        end
        chk("long_zero_count", 32'(zero_cnt), 32'd2);
        chk("long_zero_pos0",  32'(zero_pos[0]), 32'd100);
        chk("long_zero_pos1",  32'(zero_pos[1]), 32'd200);

        // Reset mid-count at 57, held 3 edges
        wait_for(57, ok);
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rst_hold", {25'd0, o_cnt}, 32'd0);
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("mid_rst_resume", {25'd0, o_cnt}, 32'(i));
        end

        // Reset at terminal count
        wait_for(99, ok);
        do_reset(1);
        chk("rst_at_99", {25'd0, o_cnt}, 32'd0);
        tick();
        chk("rst_at_99_then_1", {25'd0, o_cnt}, 32'd1);

        // Glitch between edges has no effect
        for (int g = 0; g < 3; g++) begin
            v = int'(o_cnt);
            #1 reset_n = 1'b0;
            #2 reset_n = 1'b1;
            tick();
            chk("glitch_continue", {25'd0, o_cnt}, 32'((v + 1) % PERIOD));
        end

        // Randomized run lengths, reset holds and glitches; checked by the model
        for (int seg = 0; seg < 20; seg++) begin
            int run;
            run = int'($urandom_range(1, 250));
            for (int i = 0; i < run; i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    #1 reset_n = 1'b0;
                    #2 reset_n = 1'b1;
                end
                tick();
            end
            do_reset(int'($urandom_range(1, 4)));
        end
        for (int i = 0; i < 5; i++) tick();

        @(posedge clk);
        #7;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
